// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the CPU data-memory responder.
//   state_t     : responder FSM states (INIT, IDLE, WAIT, RESP)
//   DATA_W_DEF  : default data word width
//   ADDR_W_DEF  : default request address width
//   MAX_WAIT    : largest supported WAIT_CYCLES value (sizes the wait counter)
// ---------------------------------------------------------------------------
package mem_if_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int MAX_WAIT   = 15;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W data storage, synchronous write and registered read.
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : registered read data (mem[raddr] as of the previous edge)
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder end of the CPU data-memory request/response interface. After
// reset it sweeps zeros through the storage array, then serves one load or
// store at a time, inserting WAIT_CYCLES wait states before responding.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : CPU presents a request
//   req_ready  : responder can accept a request (IDLE only)
//   req_we     : 1 = store, 0 = load
//   req_addr   : word address
//   req_wdata  : store data
//   rsp_valid  : response available, held until rsp_ready
//   rsp_ready  : CPU consumes the response
//   rsp_rdata  : load data; 0 for stores and out-of-range accesses
//   rsp_err    : address >= DEPTH
//   busy       : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  WAIT_L   = CNT_W'(WAIT_CYCLES);

    state_t             r_state;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req_ready;
    logic               r_busy;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rd_ok;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [IDX_W-1:0]   r_raddr;

    logic               w_cur_we;
    logic [ADDR_W-1:0]  w_cur_addr;
    logic [DATA_W-1:0]  w_cur_wdata;
    logic [IDX_W-1:0]   w_cur_idx;
    logic               w_in_range;
    logic               w_commit;
    logic               w_arr_we;
    logic [IDX_W-1:0]   w_arr_waddr;
    logic [DATA_W-1:0]  w_arr_wdata;
    logic [IDX_W-1:0]   w_arr_raddr;
    logic [DATA_W-1:0]  w_arr_rdata;

    // With zero wait states the commit edge is the accept edge, so the live
    // request fields are used in IDLE; otherwise the latched copies.
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_cur_idx   = w_cur_addr[IDX_W-1:0];
    assign w_in_range  = {1'b0, w_cur_addr} < DEPTH_L;

    // True during the cycle whose closing edge enters RESP.
    assign w_commit = ((r_state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

    // rst gates the write port so a store whose commit edge coincides with
    // reset is dropped.
    assign w_arr_we    = !rst && ((r_state == INIT) ||
                                  (w_commit && w_cur_we && w_in_range));
    assign w_arr_waddr = (r_state == INIT) ? r_clr_ptr : w_cur_idx;
    assign w_arr_wdata = (r_state == INIT) ? '0 : w_cur_wdata;

    // The read address only moves at a commit, so the registered read data
    // stays frozen on the last committed word. Any later store commit clears
    // r_rd_ok, so a changed array word is never exposed.
    assign w_arr_raddr = w_commit ? w_cur_idx : r_raddr;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (w_arr_we),
        .waddr  (w_arr_waddr),
        .wdata  (w_arr_wdata),
        .raddr  (w_arr_raddr),
        .rdata  (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_clr_ptr   <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_clr_ptr <= r_clr_ptr + IDX_W'(1);
                    if (r_clr_ptr == LAST_IDX) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= WAIT_L;
                        r_state     <= WAIT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= INIT;
            endcase

            // Commit edge: overrides the IDLE/WAIT next state with RESP.
            if (w_commit) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= !w_in_range;
                r_rd_ok     <= !w_cur_we && w_in_range;
                r_raddr     <= w_cur_idx;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rd_ok ? w_arr_rdata : '0;

endmodule
